// File: rtl/hilo_pkg.sv
// rtl/hilo_pkg.sv - shared constants, encodings and helpers for the HI/LO multiply/divide unit
package hilo_pkg;

    localparam int WORD_LEN   = 32;
    localparam int HILO_ITER  = 32;
    localparam int HILO_CNT_W = $clog2(HILO_ITER);

    localparam logic [HILO_CNT_W-1:0] HILO_CNT_LAST = HILO_CNT_W'(HILO_ITER - 1);

    localparam logic [1:0] HILO_MULT  = 2'd0;
    localparam logic [1:0] HILO_MULTU = 2'd1;
    localparam logic [1:0] HILO_DIV   = 2'd2;
    localparam logic [1:0] HILO_DIVU  = 2'd3;

    typedef enum logic [1:0] {
        HILO_IDLE = 2'd0,
        HILO_CALC = 2'd1,
        HILO_FIX  = 2'd2
    } hilo_state_e;

    function automatic logic is_div_op(input logic [1:0] op);
        return (op == HILO_DIV) || (op == HILO_DIVU);
    endfunction

    function automatic logic is_signed_op(input logic [1:0] op);
        return (op == HILO_MULT) || (op == HILO_DIV);
    endfunction

endpackage

// File: rtl/hilo_iter.sv
// rtl/hilo_iter.sv - one combinational shift-add or restoring-divide step
module hilo_iter
    import hilo_pkg::*;
(
    input  logic                  is_div_i,
    input  logic [2*WORD_LEN-1:0] acc_i,
    input  logic [WORD_LEN-1:0]   rem_i,
    input  logic [WORD_LEN-1:0]   opnd_i,
    output logic [2*WORD_LEN-1:0] acc_o,
    output logic [WORD_LEN-1:0]   rem_o
);

    logic [WORD_LEN:0]   sum;
    logic [WORD_LEN:0]   shifted;
    logic [WORD_LEN-1:0] diff;
    logic                ge;

    always_comb begin
        sum     = {1'b0, acc_i[2*WORD_LEN-1:WORD_LEN]}
                + {1'b0, (acc_i[0] ? opnd_i : {WORD_LEN{1'b0}})};
        // 33-bit partial remainder; the subtraction is done modulo 2^32
        // because a successful trial difference is always below the divisor.
        shifted = {rem_i, acc_i[WORD_LEN-1]};
        ge      = shifted[WORD_LEN] | (shifted[WORD_LEN-1:0] >= opnd_i);
        diff    = shifted[WORD_LEN-1:0] - opnd_i;

        acc_o = acc_i;
        rem_o = rem_i;
        if (is_div_i) begin
            rem_o = ge ? diff : shifted[WORD_LEN-1:0];
            acc_o = {acc_i[2*WORD_LEN-1:WORD_LEN], acc_i[WORD_LEN-2:0], ge};
        end else begin
            acc_o = {sum, acc_i[WORD_LEN-1:1]};
        end
    end

endmodule

// File: rtl/hilo_unit.sv
// rtl/hilo_unit.sv - iterative MULT/DIV engine and HI/LO register sequencer
module hilo_unit
    import hilo_pkg::*;
(
    input  logic                clk,
    input  logic                rst,
    input  logic                start,
    input  logic [1:0]          op,
    input  logic [WORD_LEN-1:0] src1,
    input  logic [WORD_LEN-1:0] src2,
    input  logic                wr_hi,
    input  logic                wr_lo,
    input  logic                rd_hi,
    input  logic                rd_lo,
    output logic [WORD_LEN-1:0] hi_out,
    output logic [WORD_LEN-1:0] lo_out,
    output logic                busy,
    output logic                stall_req,
    output logic                done
);

    hilo_state_e state_q, state_d;

    logic [HILO_CNT_W-1:0]   cnt_q;
    logic [1:0]              op_q;
    logic                    s1_q, s2_q, dbz_q;
    logic [WORD_LEN-1:0]     src1_q;
    logic [WORD_LEN-1:0]     opnd_q;
    logic [2*WORD_LEN-1:0]   acc_q;
    logic [WORD_LEN-1:0]     rem_q;
    logic [WORD_LEN-1:0]     hi_q, lo_q;
    logic                    done_q;

    logic                    accept;
    logic                    signed_in;
    logic [WORD_LEN-1:0]     mag1, mag2;
    logic [2*WORD_LEN-1:0]   acc_nxt;
    logic [WORD_LEN-1:0]     rem_nxt;
    logic [2*WORD_LEN-1:0]   prod;
    logic [WORD_LEN-1:0]     res_hi, res_lo;

    always_ff @(posedge clk) begin
        if (!rst) begin
            state_q <= HILO_IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    always_comb begin
        state_d = state_q;
        case (state_q)
            HILO_IDLE: if (start) state_d = HILO_CALC;
            HILO_CALC: if (cnt_q == HILO_CNT_LAST) state_d = HILO_FIX;
            HILO_FIX:  state_d = HILO_IDLE;
            default:   state_d = HILO_IDLE;
        endcase
    end

    // stall_req is built from state and raw requests only, never from itself.
    always_comb begin
        busy      = (state_q != HILO_IDLE);
        stall_req = busy & (start | wr_hi | wr_lo | rd_hi | rd_lo);
    end

    always_comb begin
        accept    = (state_q == HILO_IDLE) && start;
        signed_in = is_signed_op(op);
        mag1      = (signed_in && src1[WORD_LEN-1]) ? -src1 : src1;
        mag2      = (signed_in && src2[WORD_LEN-1]) ? -src2 : src2;
    end

    hilo_iter u_iter (
        .is_div_i (is_div_op(op_q)),
        .acc_i    (acc_q),
        .rem_i    (rem_q),
        .opnd_i   (opnd_q),
        .acc_o    (acc_nxt),
        .rem_o    (rem_nxt)
    );

    // Sign bits are latched pre-gated by signedness, so s1^s2 alone drives the fix-up.
    always_comb begin
        prod   = (s1_q ^ s2_q) ? -acc_q : acc_q;
        res_hi = prod[2*WORD_LEN-1:WORD_LEN];
        res_lo = prod[WORD_LEN-1:0];
        if (is_div_op(op_q)) begin
            if (dbz_q) begin
                res_hi = src1_q;
                res_lo = '1;
            end else begin
                res_lo = (s1_q ^ s2_q) ? -acc_q[WORD_LEN-1:0] : acc_q[WORD_LEN-1:0];
                res_hi = s1_q ? -rem_q : rem_q;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (!rst) begin
            cnt_q  <= '0;
            op_q   <= HILO_MULT;
            s1_q   <= 1'b0;
            s2_q   <= 1'b0;
            dbz_q  <= 1'b0;
            src1_q <= '0;
            opnd_q <= '0;
            acc_q  <= '0;
            rem_q  <= '0;
            hi_q   <= '0;
            lo_q   <= '0;
            done_q <= 1'b0;
        end else begin
            done_q <= 1'b0;
            case (state_q)
                HILO_IDLE: begin
                    if (accept) begin
                        op_q   <= op;
                        s1_q   <= signed_in & src1[WORD_LEN-1];
                        s2_q   <= signed_in & src2[WORD_LEN-1];
                        dbz_q  <= (src2 == '0);
                        src1_q <= src1;
                        cnt_q  <= '0;
                        rem_q  <= '0;
                        acc_q  <= {{WORD_LEN{1'b0}}, (is_div_op(op) ? mag1 : mag2)};
                        opnd_q <= is_div_op(op) ? mag2 : mag1;
                    end else begin
                        if (wr_hi) hi_q <= src1;
                        if (wr_lo) lo_q <= src1;
                    end
                end
                HILO_CALC: begin
                    acc_q <= acc_nxt;
                    rem_q <= rem_nxt;
                    cnt_q <= cnt_q + 1'b1;
                end
                HILO_FIX: begin
                    hi_q   <= res_hi;
                    lo_q   <= res_lo;
                    done_q <= 1'b1;
                end
                default: ;
            endcase
        end
    end

    assign hi_out = hi_q;
    assign lo_out = lo_q;
    assign done   = done_q;

endmodule

// File: tb/tb_hilo_unit.sv
// tb/tb_hilo_unit.sv - scoreboard testbench for hilo_unit
module tb_hilo_unit;
    import hilo_pkg::*;

    logic        clk = 1'b0;
    logic        rst = 1'b0;
    logic        start = 1'b0;
    logic [1:0]  op = 2'd0;
    logic [31:0] src1 = '0, src2 = '0;
    logic        wr_hi = 1'b0, wr_lo = 1'b0, rd_hi = 1'b0, rd_lo = 1'b0;
    logic [31:0] hi_out, lo_out;
    logic        busy, stall_req, done;

    int checks = 0;
    int failures = 0;
    logic [63:0] exp_q[$];

    hilo_unit dut (
        .clk(clk), .rst(rst), .start(start), .op(op), .src1(src1), .src2(src2),
        .wr_hi(wr_hi), .wr_lo(wr_lo), .rd_hi(rd_hi), .rd_lo(rd_lo),
        .hi_out(hi_out), .lo_out(lo_out), .busy(busy), .stall_req(stall_req), .done(done)
    );

    always #5 clk = ~clk;

    function automatic logic [63:0] model(input logic [1:0] o, input logic [31:0] a, input logic [31:0] b);
        logic [63:0] p;
        logic [31:0] q, r;
        case (o)
            HILO_MULT:  p = {{32{a[31]}}, a} * {{32{b[31]}}, b};
            HILO_MULTU: p = {32'b0, a} * {32'b0, b};
            HILO_DIV: begin
                if (b == 32'h0) p = {a, 32'hFFFF_FFFF};
                else if (a == 32'h8000_0000 && b == 32'hFFFF_FFFF) p = {32'h0, 32'h8000_0000};
                else begin
                    q = $signed(a) / $signed(b);
                    r = $signed(a) % $signed(b);
                    p = {r, q};
                end
            end
            default: begin
                if (b == 32'h0) p = {a, 32'hFFFF_FFFF};
                else p = {a % b, a / b};
            end
        endcase
        return p;
    endfunction

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic issue(input logic [1:0] o, input logic [31:0] a, input logic [31:0] b);
        exp_q.push_back(model(o, a, b));
        start = 1'b1;
        op    = o;
        src1  = a;
        src2  = b;
        tick();
        start = 1'b0;
    endtask

    task automatic wait_done(output int lat, output int busy_bad);
        lat = -1;
        busy_bad = 0;
        for (int n = 1; n <= 60; n++) begin
            if (done === 1'b1) begin
                lat = n;
                break;
            end
            if (busy !== 1'b1) busy_bad++;
            tick();
        end
    endtask

    task automatic test_reset();
        logic [63:0] obs;
        rst = 1'b0;
        tick();
        tick();
        obs = {hi_out, lo_out};
        checks++; if (obs !== 64'h0) begin failures++; $display("FAIL reset_hilo got=%h exp=0", obs); end
        checks++; if ({busy, stall_req, done} !== 3'b000) begin failures++; $display("FAIL reset_flags got=%b exp=000", {busy, stall_req, done}); end
        rst = 1'b1;
        tick();
    endtask

    task automatic test_multu_max();
        int lat, bb;
        logic [63:0] exp;
        issue(HILO_MULTU, 32'hFFFF_FFFF, 32'hFFFF_FFFF);
        wait_done(lat, bb);
        exp = exp_q.pop_front();
        checks++; if (lat !== 34) begin failures++; $display("FAIL multu_latency got=%0d exp=34", lat); end
        checks++; if (bb !== 0) begin failures++; $display("FAIL multu_busy_window got=%0d low cycles exp=0", bb); end
        checks++; if ({hi_out, lo_out} !== exp) begin failures++; $display("FAIL multu_result got=%h exp=%h", {hi_out, lo_out}, exp); end
        checks++; if (busy !== 1'b0) begin failures++; $display("FAIL multu_busy_at_done got=%b exp=0", busy); end
        tick();
        checks++; if (done !== 1'b0) begin failures++; $display("FAIL multu_done_pulse got=%b exp=0", done); end
    endtask

    task automatic test_signed();
        int lat, bb;
        logic [63:0] exp;
        issue(HILO_MULT, 32'hFFFF_FFFD, 32'h0000_0005);
        wait_done(lat, bb);
        exp = exp_q.pop_front();
        checks++; if ({hi_out, lo_out} !== exp) begin failures++; $display("FAIL mult_neg got=%h exp=%h", {hi_out, lo_out}, exp); end
        issue(HILO_DIV, 32'hFFFF_FFF9, 32'h0000_0002);
        wait_done(lat, bb);
        exp = exp_q.pop_front();
        checks++; if ({hi_out, lo_out} !== exp) begin failures++; $display("FAIL div_neg got=%h exp=%h", {hi_out, lo_out}, exp); end
        checks++; if (lat !== 34) begin failures++; $display("FAIL div_latency got=%0d exp=34", lat); end
    endtask

    task automatic test_div_by_zero();
        int lat, bb;
        logic [63:0] exp;
        issue(HILO_DIVU, 32'd10, 32'd0);
        wait_done(lat, bb);
        exp = exp_q.pop_front();
        checks++; if (lat !== 34) begin failures++; $display("FAIL dbz_latency got=%0d exp=34", lat); end
        checks++; if ({hi_out, lo_out} !== exp) begin failures++; $display("FAIL divu_dbz got=%h exp=%h", {hi_out, lo_out}, exp); end
        issue(HILO_DIV, 32'hFFFF_FFF9, 32'd0);
        wait_done(lat, bb);
        exp = exp_q.pop_front();
        checks++; if ({hi_out, lo_out} !== exp) begin failures++; $display("FAIL div_dbz_neg got=%h exp=%h", {hi_out, lo_out}, exp); end
    endtask

    task automatic test_stall_rd();
        int stall_bad;
        logic [63:0] exp;
        stall_bad = 0;
        issue(HILO_DIVU, 32'd100, 32'd7);
        rd_lo = 1'b1;
        for (int n = 1; n <= 33; n++) begin
            start = (n == 5);
            src1  = 32'd3;
            src2  = 32'd3;
            op    = HILO_MULTU;
            #1;
            if (stall_req !== 1'b1) stall_bad++;
            if (n == 5) begin
                checks++; if (stall_req !== 1'b1) begin failures++; $display("FAIL stall_on_busy_start got=%b exp=1", stall_req); end
            end
            @(posedge clk);
            #1;
        end
        start = 1'b0;
        #1;
        checks++; if (stall_bad !== 0) begin failures++; $display("FAIL stall_window got=%0d unstalled cycles exp=0", stall_bad); end
        checks++; if (stall_req !== 1'b0) begin failures++; $display("FAIL stall_release got=%b exp=0", stall_req); end
        checks++; if (done !== 1'b1) begin failures++; $display("FAIL stall_done got=%b exp=1", done); end
        exp = exp_q.pop_front();
        checks++; if ({hi_out, lo_out} !== exp) begin failures++; $display("FAIL divu_100_7 got=%h exp=%h", {hi_out, lo_out}, exp); end
        rd_lo = 1'b0;
        tick();
        checks++; if (busy !== 1'b0) begin failures++; $display("FAIL busy_start_dropped got=%b exp=0", busy); end
    endtask

    task automatic test_mthi_mtlo();
        int bad;
        logic [63:0] exp;
        wr_hi = 1'b1;
        src1  = 32'h1234_5678;
        #1;
        checks++; if (stall_req !== 1'b0) begin failures++; $display("FAIL mthi_stall got=%b exp=0", stall_req); end
        tick();
        wr_hi = 1'b0;
        checks++; if (hi_out !== 32'h1234_5678) begin failures++; $display("FAIL mthi got=%h exp=12345678", hi_out); end
        wr_lo = 1'b1;
        src1  = 32'h9ABC_DEF0;
        tick();
        wr_lo = 1'b0;
        checks++; if (lo_out !== 32'h9ABC_DEF0) begin failures++; $display("FAIL mtlo got=%h exp=9abcdef0", lo_out); end
        wr_hi = 1'b1;
        wr_lo = 1'b1;
        src1  = 32'h55AA_33CC;
        tick();
        wr_hi = 1'b0;
        wr_lo = 1'b0;
        checks++; if ({hi_out, lo_out} !== {2{32'h55AA_33CC}}) begin failures++; $display("FAIL mthi_mtlo_both got=%h exp=%h", {hi_out, lo_out}, {2{32'h55AA_33CC}}); end

        issue(HILO_MULTU, 32'd2, 32'd3);
        wr_lo = 1'b1;
        src1  = 32'hDEAD_BEEF;
        bad   = 0;
        for (int n = 1; n <= 33; n++) begin
            if (stall_req !== 1'b1 || lo_out !== 32'h55AA_33CC) bad++;
            tick();
        end
        checks++; if (bad !== 0) begin failures++; $display("FAIL mtlo_busy_held got=%0d bad cycles exp=0", bad); end
        exp = exp_q.pop_front();
        checks++; if ({hi_out, lo_out} !== exp) begin failures++; $display("FAIL mtlo_busy_result got=%h exp=%h", {hi_out, lo_out}, exp); end
        tick();
        wr_lo = 1'b0;
        checks++; if (lo_out !== 32'hDEAD_BEEF) begin failures++; $display("FAIL mtlo_replayed got=%h exp=deadbeef", lo_out); end
    endtask

    task automatic test_reset_midop();
        int done_seen;
        issue(HILO_MULTU, 32'hFFFF_FFFF, 32'hFFFF_FFFF);
        exp_q.delete();
        for (int n = 1; n < 10; n++) tick();
        rst = 1'b0;
        tick();
        rst = 1'b1;
        checks++; if (busy !== 1'b0) begin failures++; $display("FAIL midrst_busy got=%b exp=0", busy); end
        checks++; if ({hi_out, lo_out} !== 64'h0) begin failures++; $display("FAIL midrst_hilo got=%h exp=0", {hi_out, lo_out}); end
        done_seen = 0;
        for (int n = 0; n < 40; n++) begin
            if (done !== 1'b0) done_seen++;
            tick();
        end
        checks++; if (done_seen !== 0) begin failures++; $display("FAIL midrst_done got=%0d pulses exp=0", done_seen); end
    endtask

    task automatic test_back_to_back();
        logic [1:0]  ops[10];
        logic [31:0] as[10], bs[10];
        logic [63:0] exp;
        int lat, bb;
        ops[0] = HILO_DIV;   as[0] = 32'h8000_0000; bs[0] = 32'hFFFF_FFFF;
        ops[1] = HILO_MULT;  as[1] = 32'h8000_0000; bs[1] = 32'h8000_0000;
        ops[2] = HILO_DIVU;  as[2] = 32'hFFFF_FFFF; bs[2] = 32'h0000_0001;
        ops[3] = HILO_DIV;   as[3] = 32'h0000_0007; bs[3] = 32'hFFFF_FFFE;
        for (int i = 4; i < 10; i++) begin
            ops[i] = 2'($urandom_range(0, 3));
            as[i]  = $urandom;
            bs[i]  = (i == 9) ? 32'($urandom_range(1, 255)) : $urandom;
        end
        issue(ops[0], as[0], bs[0]);
        for (int i = 0; i < 10; i++) begin
            wait_done(lat, bb);
            exp = exp_q.pop_front();
            checks++; if (lat !== 34) begin failures++; $display("FAIL b2b_latency_%0d got=%0d exp=34", i, lat); end
            checks++; if ({hi_out, lo_out} !== exp) begin failures++; $display("FAIL b2b_result_%0d op=%0d a=%h b=%h got=%h exp=%h", i, ops[i], as[i], bs[i], {hi_out, lo_out}, exp); end
            if (i < 9) issue(ops[i+1], as[i+1], bs[i+1]);
        end
        tick();
    endtask

    initial begin
        test_reset();
        test_multu_max();
        test_signed();
        test_div_by_zero();
        test_stall_rd();
        test_mthi_mtlo();
        test_reset_midop();
        test_back_to_back();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
